// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake, feeds the IF/ID register.
// A one-entry skid buffer absorbs a return that lands during a decode stall.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_addr,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_out,
   output logic [31:0] pc4_out,
   output logic        valid_out
);

   typedef enum logic {S_FETCH, S_DISCARD} state_t;

   state_t      state_q, state_d;
   logic [31:0] fetch_addr_q, fetch_addr_d;
   logic [31:0] redirect_pc_q, redirect_pc_d;
   logic [31:0] ifid_instr_q, ifid_instr_d;
   logic [31:0] ifid_pc4_q, ifid_pc4_d;
   logic        ifid_valid_q, ifid_valid_d;
   logic [31:0] skid_instr_q, skid_instr_d;
   logic [31:0] skid_pc4_q, skid_pc4_d;
   logic        skid_valid_q, skid_valid_d;

   logic        redirect;
   logic [31:0] target;
   logic        accept;
   logic [31:0] acc_pc4;

   assign redirect  = branch_taken | jump;
   assign target    = branch_taken ? branch_target : jump_addr;
   assign imem_req  = rst & (((state_q == S_FETCH) & ~skid_valid_q) | (state_q == S_DISCARD));
   assign imem_addr = fetch_addr_q;
   assign accept    = (state_q == S_FETCH) & imem_req & imem_ack & ~redirect;
   assign acc_pc4   = fetch_addr_q + 32'd4;

   assign instr_out = ifid_instr_q;
   assign pc4_out   = ifid_pc4_q;
   assign valid_out = ifid_valid_q;

   always_comb begin
      state_d       = state_q;
      fetch_addr_d  = fetch_addr_q;
      redirect_pc_d = redirect_pc_q;
      ifid_instr_d  = ifid_instr_q;
      ifid_pc4_d    = ifid_pc4_q;
      ifid_valid_d  = ifid_valid_q;
      skid_instr_d  = skid_instr_q;
      skid_pc4_d    = skid_pc4_q;
      skid_valid_d  = skid_valid_q;

      if (redirect) begin
         ifid_valid_d = 1'b0;
         skid_valid_d = 1'b0;
         if (state_q == S_FETCH) begin
            // An unacked request must keep its address, so park the target until it returns.
            if (imem_req && !imem_ack) begin
               redirect_pc_d = target;
               state_d       = S_DISCARD;
            end else begin
               fetch_addr_d = target;
            end
         end else if (imem_ack) begin
            fetch_addr_d = target;
            state_d      = S_FETCH;
         end else begin
            redirect_pc_d = target;
         end
      end else begin
         if (state_q == S_FETCH) begin
            if (accept) fetch_addr_d = acc_pc4;
         end else if (imem_ack) begin
            fetch_addr_d = redirect_pc_q;
            state_d      = S_FETCH;
         end

         if (!stall) begin
            if (skid_valid_q) begin
               ifid_instr_d = skid_instr_q;
               ifid_pc4_d   = skid_pc4_q;
               ifid_valid_d = 1'b1;
               skid_valid_d = accept;
               if (accept) begin
                  skid_instr_d = imem_rdata;
                  skid_pc4_d   = acc_pc4;
               end
            end else if (accept) begin
               ifid_instr_d = imem_rdata;
               ifid_pc4_d   = acc_pc4;
               ifid_valid_d = 1'b1;
            end else begin
               ifid_valid_d = 1'b0;
            end
         end else if (accept) begin
            skid_instr_d = imem_rdata;
            skid_pc4_d   = acc_pc4;
            skid_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= S_FETCH;
         fetch_addr_q  <= RESET_PC;
         redirect_pc_q <= '0;
         ifid_instr_q  <= '0;
         ifid_pc4_q    <= '0;
         ifid_valid_q  <= 1'b0;
         skid_instr_q  <= '0;
         skid_pc4_q    <= '0;
         skid_valid_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         fetch_addr_q  <= fetch_addr_d;
         redirect_pc_q <= redirect_pc_d;
         ifid_instr_q  <= ifid_instr_d;
         ifid_pc4_q    <= ifid_pc4_d;
         ifid_valid_q  <= ifid_valid_d;
         skid_instr_q  <= skid_instr_d;
         skid_pc4_q    <= skid_pc4_d;
         skid_valid_q  <= skid_valid_d;
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: a latency-configurable memory responder pushes expected
// IF/ID contents on each accepted return; they are popped and compared as IF/ID advances.
module tb_if_fetch_stage;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = '0;
   logic        jump = 1'b0;
   logic [31:0] jump_addr = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] instr_out;
   logic [31:0] pc4_out;
   logic        valid_out;

   if_fetch_stage #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .rst(rst), .stall(stall),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .jump(jump), .jump_addr(jump_addr),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr_out(instr_out), .pc4_out(pc4_out), .valid_out(valid_out)
   );

   always #5 clk = ~clk;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   logic [63:0] exp_q[$];
   logic [31:0] exp_addr = RST_PC;
   logic        pending = 1'b0;
   logic [31:0] pend_tgt = '0;
   int unsigned lat = 1;
   int unsigned wait_cnt = 0;
   logic        stall_v = 1'b0;
   logic        prev_rst = 1'b0;
   logic        prev_redir = 1'b0;
   logic        prev_stall = 1'b0;
   logic        held_valid = 1'b0;
   logic [63:0] held_data = '0;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: check IF/ID from the last edge, drive inputs, answer memory, update model.
   task automatic cyc(input logic r, input logic br, input logic [31:0] bt,
                      input logic jp, input logic [31:0] ja);
      logic        a;
      logic [31:0] tgt;
      logic [63:0] e;
      @(negedge clk);
      if (!prev_rst) begin
         chk("reset_valid", 64'(valid_out), 64'd0);
         chk("reset_ifid", {instr_out, pc4_out}, 64'd0);
         held_valid = 1'b0;
      end else if (prev_redir) begin
         chk("flush_valid", 64'(valid_out), 64'd0);
         held_valid = 1'b0;
      end else if (prev_stall) begin
         chk("stall_hold_valid", 64'(valid_out), 64'(held_valid));
         if (held_valid) chk("stall_hold_data", {instr_out, pc4_out}, held_data);
      end else if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("ifid_valid", 64'(valid_out), 64'd1);
         chk("ifid_data", {instr_out, pc4_out}, e);
         held_valid = 1'b1;
         held_data  = e;
      end else begin
         chk("bubble", 64'(valid_out), 64'd0);
         held_valid = 1'b0;
      end

      rst = r; stall = stall_v;
      branch_taken = br; branch_target = bt; jump = jp; jump_addr = ja;
      #1;
      a = 1'b0;
      if (!r) chk("req_in_reset", 64'(imem_req), 64'd0);
      if (r && imem_req) begin
         chk("imem_addr", 64'(imem_addr), 64'(exp_addr));
         if (wait_cnt + 1 >= lat) begin
            a = 1'b1;
            wait_cnt = 0;
         end else begin
            wait_cnt++;
         end
      end
      imem_ack   = a;
      imem_rdata = a ? mem(imem_addr) : 32'hDEAD_BEEF;

      tgt = br ? bt : ja;
      if (!r) begin
         exp_q.delete();
         pending  = 1'b0;
         exp_addr = RST_PC;
         wait_cnt = 0;
      end else if (br || jp) begin
         exp_q.delete();
         if (pending) begin
            if (a) begin
               exp_addr = tgt;
               pending  = 1'b0;
            end else begin
               pend_tgt = tgt;
            end
         end else if (imem_req && !a) begin
            pending  = 1'b1;
            pend_tgt = tgt;
         end else begin
            exp_addr = tgt;
         end
      end else if (a) begin
         if (pending) begin
            exp_addr = pend_tgt;
            pending  = 1'b0;
         end else begin
            exp_q.push_back({mem(exp_addr), exp_addr + 32'd4});
            exp_addr = exp_addr + 32'd4;
         end
      end
      prev_rst   = r;
      prev_redir = r && (br || jp);
      prev_stall = stall_v;
   endtask

   task automatic run(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) cyc(1'b1, 1'b0, '0, 1'b0, '0);
   endtask

   // Advance until the memory model starts a fresh wait, so the next request is still unacked.
   task automatic sync_fresh();
      for (int unsigned i = 0; i < 8 && wait_cnt != 0; i++) run(1);
   endtask

   initial begin
      // reset
      cyc(1'b0, 1'b0, '0, 1'b0, '0);
      cyc(1'b0, 1'b0, '0, 1'b0, '0);
      // zero-wait streaming from RESET_PC
      lat = 1;
      run(8);
      // 3-cycle ack latency
      lat = 3;
      run(12);
      // stall with zero-wait memory: one word buffered, then req drops
      lat = 1;
      run(3);
      stall_v = 1'b1;
      for (int unsigned i = 0; i < 4; i++) begin
         cyc(1'b1, 1'b0, '0, 1'b0, '0);
         if (i > 0) chk("stall_req_low", 64'(imem_req), 64'd0);
      end
      stall_v = 1'b0;
      run(6);
      // branch while a request is outstanding
      lat = 3;
      sync_fresh();
      cyc(1'b1, 1'b1, 32'h0000_0200, 1'b0, '0);
      run(10);
      // branch and jump together: branch wins
      lat = 1;
      cyc(1'b1, 1'b1, 32'h0000_0300, 1'b1, 32'h0000_0400);
      run(5);
      // redirect during stall flushes ifid and skid
      stall_v = 1'b1;
      run(3);
      cyc(1'b1, 1'b0, '0, 1'b1, 32'h0000_0500);
      run(1);
      stall_v = 1'b0;
      run(5);
      // back-to-back redirects while discarding: latest wins
      lat = 3;
      sync_fresh();
      cyc(1'b1, 1'b1, 32'h0000_0700, 1'b0, '0);
      cyc(1'b1, 1'b0, '0, 1'b1, 32'h0000_0800);
      run(10);
      // reset in the middle of a discard
      lat = 4;
      sync_fresh();
      cyc(1'b1, 1'b1, 32'h0000_0600, 1'b0, '0);
      cyc(1'b0, 1'b0, '0, 1'b0, '0);
      lat = 1;
      run(5);
      // PC wrap at the top of the address space
      cyc(1'b1, 1'b0, '0, 1'b1, 32'hFFFF_FFFC);
      run(5);
      cyc(1'b0, 1'b0, '0, 1'b0, '0);
      cyc(1'b0, 1'b0, '0, 1'b0, '0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
